qupls4_regfile_wport_arbiter: RTL and testbench
===============================================

// Module: qupls4_regfile_wport_arbiter
// PURPOSE
//  Shares the register file's WPORTS write ports among NREQ result producers (ALUs, FPU, load unit, ...).
//  Each cycle it grants up to WPORTS requests, with round-robin fairness and starvation escalation.
//  Grants are registered onto the register file write bus (wr/we/wa/i/ti) one cycle after acceptance.
//  Two writes to the same physical register in one cycle are never issued, which keeps the live value table coherent.
// PARAMETERS
//  NREQ       8                       number of requesters
//  WPORTS     4                       register file write ports (must be <= NREQ)
//  BWW        8                       byte-enable granule, in bits
//  WEW        (value+flags bits)/BWW+1  width of one write-enable vector
//  STARVE_LIM 7                       wait cycles before a requester is escalated (counter is 3 bits)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous, active-high reset
//  req_valid    in   NREQ               requester n has a result to write
//  req_ready    out  NREQ               grant; the transfer occurs when req_valid[n] && req_ready[n]
//  req_pr       in   pregno_t[NREQ]     destination physical register
//  req_we       in   WEW[NREQ]          byte enables
//  req_val      in   value_t[NREQ]      result value
//  req_flg      in   flags_t[NREQ]      result flags
//  wr           out  WPORTS             per-port write strobe to the register file
//  we           out  WEW[WPORTS]        per-port byte enables
//  wa           out  pregno_t[WPORTS]   per-port write address
//  i            out  value_t[WPORTS]    per-port write data
//  ti           out  flags_t[WPORTS]    per-port write flags
//  starve       out  1                  registered; 1 if any requester's wait counter is at STARVE_LIM
// BEHAVIOUR
//  Reset (clk edge with rst=1):
//   - wr, we, wa, i, ti, rr_ptr, wait counters and starve are all cleared to 0.
//   - While rst=1, req_ready is forced to 0.
//  Grant pass (combinational, evaluated each cycle):
//   - Candidates are the requesters with req_valid=1.
//   - Scan order: first, escalated candidates (wait counter == STARVE_LIM), in rotation order starting from rr_ptr.
//   - Then the remaining candidates, in rotation order starting from rr_ptr.
//   - Rotation order is rr_ptr, rr_ptr+1, ... modulo NREQ.
//   - Take the first WPORTS candidates, skipping any whose req_pr equals the req_pr of a candidate already taken.
//     A skipped candidate waits; it is not merged with the earlier write.
//   - The k-th taken candidate drives write port k (port 0 = first taken).
//   - req_ready[n] = 1 iff n is taken. req_ready never depends on req_ready.
//  Register stage (posedge, rst=0):
//   - For each port k with a taken candidate: wr[k]=1, and we/wa/i/ti are copied from that candidate.
//   - For each unused port: wr[k]=0 and we[k]=0. wa/i/ti may hold stale values.
//   - Latency is exactly 1 cycle from acceptance to wr. The arbiter has no backpressure from the register file.
//  rr_ptr update:
//   - If at least one request was granted, rr_ptr becomes (index of the last taken candidate in scan order + 1) mod NREQ.
//   - Otherwise rr_ptr is unchanged.
//  Wait counter n:
//   - Cleared when n is granted or when req_valid[n]=0.
//   - Otherwise (valid, not granted) incremented, saturating at STARVE_LIM.
//  Boundary cases:
//   - No candidates: wr=0 on the next cycle; nothing else changes.
//   - Number of candidates <= WPORTS and no duplicate req_pr: all candidates are granted in the same cycle.
//   - Requester valid but not granted: it must hold req_pr/req_we/req_val/req_flg stable until granted.
//   - More than WPORTS requesters escalated: the escalated ones are served in rotation order; the rest stay saturated.
//   - Same req_pr held by an escalated and a non-escalated candidate: the escalated one wins.
//   - rst asserted mid-operation: any in-flight registered write is dropped (wr=0 on the next edge).
//     Requesters retain their valids and must re-request.
// STRUCTURE
//  - Qupls4_pkg gains the STARVE_LIM default and typedef wport_sel_t (index of one requester, $clog2(NREQ) bits).
//  - pregno_t and value_t come from cpu_types_pkg; flags_t comes from Qupls4_pkg.
//  - Sub-module qupls4_rr_pick_k: from a request mask, a blocked mask and a rotate start, returns up to K
//    one-hot picks in rotation order. Duplicate-req_pr blocking is resolved in the parent by cascading
//    WPORTS single picks.
//  - Top level holds rr_ptr, the wait counters, the output register stage and the escalation mask.
// TESTING
//  1. Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0 and wr=0; the first grant appears only after rst drops.
//  2. Four valids (req 0,2,5,7), distinct pregs, rr_ptr=0 -> all four granted at once;
//     next cycle wr=4'b1111, wa = {p7,p5,p2,p0} (ports 3..0).
//  3. All 8 valid, distinct pregs, held -> grants alternate {0-3},{4-7},{0-3},...; rr_ptr goes 0->4->0.
//  4. req1 and req3 both target preg 42, rr_ptr=0 -> req1 granted, req3 waits; req3 is granted the next cycle;
//     wr never shows two ports with wa=42.
//  5. Starvation: req6 valid while 7 others re-request continuously (rr_ptr forced) -> once req6's counter reaches 7,
//     starve=1 and req6 is granted on port 0 the next cycle.
//  6. rst asserted in the cycle after a 3-port grant -> wr=0 on the following edge; rr_ptr=0; counters=0.

Source files
------------

// File: rtl/qupls4_regfile_wport_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Value/flag widths set the byte-enable vector width.
package qupls4_regfile_wport_arbiter_pkg;

    localparam int NREQ_DEF   = 8;
    localparam int WPORTS_DEF = 4;
    localparam int BWW        = 8;
    localparam int VALW       = 64;
    localparam int FLGW       = 8;
    localparam int PREGW      = 9;
    localparam int WEW        = (VALW + FLGW) / BWW + 1;
    localparam int STARVE_LIM = 7;
    localparam int CNTW       = 3;

    typedef logic [PREGW-1:0] pregno_t;
    typedef logic [VALW-1:0]  value_t;
    typedef logic [FLGW-1:0]  flags_t;
    typedef logic [WEW-1:0]   wen_t;
    typedef logic [CNTW-1:0]  wcnt_t;
    typedef logic [$clog2(NREQ_DEF)-1:0] wport_sel_t;

    localparam wcnt_t WAIT_MAX = wcnt_t'(STARVE_LIM);

endpackage

// File: rtl/qupls4_regfile_wport_arbiter_rr_pick_k.sv
// Picks up to K requesters (one-hot each) in rotation order from i_start,
// ignoring any requester whose i_blk bit is set.
module qupls4_regfile_wport_arbiter_rr_pick_k #(
    parameter int N  = 8,
    parameter int K  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_blk,
    input  logic [SW-1:0] i_start,
    output logic [N-1:0]  o_pick [K],
    output logic [K-1:0]  o_any
);

    always_comb begin
        int            cnt;
        logic [SW-1:0] idx;
        cnt   = 0;
        idx   = '0;
        o_any = '0;
        for (int k = 0; k < K; k++) o_pick[k] = '0;
        for (int j = 0; j < N; j++) begin
            idx = SW'((int'(i_start) + j) % N);
            if (i_req[idx] && !i_blk[idx]) begin
                for (int k = 0; k < K; k++) begin
                    if (cnt == k) begin
                        o_pick[k][idx] = 1'b1;
                        o_any[k]       = 1'b1;
                    end
                end
                cnt++;
            end
        end
    end

endmodule

// File: rtl/qupls4_regfile_wport_arbiter.sv
// Shares WPORTS register-file write ports among NREQ producers: round-robin,
// starvation escalation, no two same-cycle writes to one physical register.
module qupls4_regfile_wport_arbiter
    import qupls4_regfile_wport_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int WPORTS = WPORTS_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  pregno_t           i_req_pr  [NREQ],
    input  wen_t              i_req_we  [NREQ],
    input  value_t            i_req_val [NREQ],
    input  flags_t            i_req_flg [NREQ],
    output logic [WPORTS-1:0] o_wr,
    output wen_t              o_we [WPORTS],
    output pregno_t           o_wa [WPORTS],
    output value_t            o_i  [WPORTS],
    output flags_t            o_ti [WPORTS],
    output logic              o_starve
);

    localparam int SELW = $clog2(NREQ);

    logic [SELW-1:0]   r_rr_ptr;
    wcnt_t             r_wait_cnt [NREQ];
    logic              r_starve;
    logic [WPORTS-1:0] r_wr;
    wen_t              r_we [WPORTS];
    pregno_t           r_wa [WPORTS];
    value_t            r_i  [WPORTS];
    flags_t            r_ti [WPORTS];

    logic [NREQ-1:0]   w_esc;
    logic [NREQ-1:0]   w_granted;
    logic [NREQ-1:0]   w_taken [WPORTS+1];
    logic [NREQ-1:0]   w_blk   [WPORTS+1];
    logic [WPORTS-1:0] w_port_any;
    logic [SELW-1:0]   w_port_idx [WPORTS];
    logic [SELW-1:0]   w_rr_nxt;
    wcnt_t             w_wait_nxt [NREQ];
    logic              w_starve_nxt;

    always_comb begin
        for (int n = 0; n < NREQ; n++) w_esc[n] = (r_wait_cnt[n] == WAIT_MAX);
    end

    assign w_taken[0] = '0;
    assign w_blk[0]   = '0;

    // Each port takes the first still-eligible requester, escalated ones first;
    // its preg then blocks every later port from the same destination.
    for (genvar k = 0; k < WPORTS; k++) begin : g_port
        logic [NREQ-1:0] w_avail;
        logic [NREQ-1:0] w_esc_pick [1];
        logic [NREQ-1:0] w_any_pick [1];
        logic [0:0]      w_esc_hit;
        logic [0:0]      w_any_hit;
        logic [NREQ-1:0] w_oh;
        logic [SELW-1:0] w_idx;
        pregno_t         w_pr;
        logic [NREQ-1:0] w_blk_add;

        assign w_avail = i_req_valid & ~w_taken[k] & ~w_blk[k];

        qupls4_regfile_wport_arbiter_rr_pick_k #(.N(NREQ), .K(1)) u_pick_esc (
            .i_req   (w_avail),
            .i_blk   (~w_esc),
            .i_start (r_rr_ptr),
            .o_pick  (w_esc_pick),
            .o_any   (w_esc_hit)
        );

        qupls4_regfile_wport_arbiter_rr_pick_k #(.N(NREQ), .K(1)) u_pick_any (
            .i_req   (w_avail),
            .i_blk   ({NREQ{1'b0}}),
            .i_start (r_rr_ptr),
            .o_pick  (w_any_pick),
            .o_any   (w_any_hit)
        );

        assign w_oh          = w_esc_hit[0] ? w_esc_pick[0] : w_any_pick[0];
        assign w_port_any[k] = w_any_hit[0];
        assign w_taken[k+1]  = w_taken[k] | w_oh;

        always_comb begin
            w_idx = '0;
            for (int n = 0; n < NREQ; n++) begin
                if (w_oh[n]) w_idx = SELW'(n);
            end
        end

        assign w_port_idx[k] = w_idx;
        assign w_pr          = i_req_pr[w_idx];

        always_comb begin
            for (int n = 0; n < NREQ; n++) begin
                w_blk_add[n] = w_any_hit[0] && (i_req_pr[n] == w_pr);
            end
        end

        assign w_blk[k+1] = w_blk[k] | w_blk_add;
    end

    assign w_granted   = w_taken[WPORTS];
    assign o_req_ready = i_rst ? '0 : w_granted;

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        for (int k = 0; k < WPORTS; k++) begin
            if (w_port_any[k]) w_rr_nxt = SELW'((int'(w_port_idx[k]) + 1) % NREQ);
        end
    end

    always_comb begin
        w_starve_nxt = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            if (!i_req_valid[n] || w_granted[n]) begin
                w_wait_nxt[n] = '0;
            end else if (w_esc[n]) begin
                w_wait_nxt[n] = r_wait_cnt[n];
            end else begin
                w_wait_nxt[n] = wcnt_t'(r_wait_cnt[n] + 1'b1);
            end
            w_starve_nxt = w_starve_nxt | (w_wait_nxt[n] == WAIT_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
            r_starve <= 1'b0;
            r_wr     <= '0;
            for (int n = 0; n < NREQ; n++) r_wait_cnt[n] <= '0;
            for (int k = 0; k < WPORTS; k++) begin
                r_we[k] <= '0;
                r_wa[k] <= '0;
                r_i[k]  <= '0;
                r_ti[k] <= '0;
            end
        end else begin
            r_rr_ptr <= w_rr_nxt;
            r_starve <= w_starve_nxt;
            r_wr     <= w_port_any;
            for (int n = 0; n < NREQ; n++) r_wait_cnt[n] <= w_wait_nxt[n];
            for (int k = 0; k < WPORTS; k++) begin
                if (w_port_any[k]) begin
                    r_we[k] <= i_req_we[w_port_idx[k]];
                    r_wa[k] <= i_req_pr[w_port_idx[k]];
                    r_i[k]  <= i_req_val[w_port_idx[k]];
                    r_ti[k] <= i_req_flg[w_port_idx[k]];
                end else begin
                    r_we[k] <= '0;
                end
            end
        end
    end

    assign o_wr     = r_wr;
    assign o_we     = r_we;
    assign o_wa     = r_wa;
    assign o_i      = r_i;
    assign o_ti     = r_ti;
    assign o_starve = r_starve;

endmodule

// File: tb/tb_qupls4_regfile_wport_arbiter.sv
// Bench for the write-port arbiter: a reference model of the grant rules
// fills an expected queue each cycle; scenario tasks compare and add directed checks.
module tb_qupls4_regfile_wport_arbiter;
    import qupls4_regfile_wport_arbiter_pkg::*;

    localparam int NR   = 8;
    localparam int NP   = 4;
    localparam int PW   = $bits(wen_t) + $bits(pregno_t) + $bits(value_t) + $bits(flags_t);
    localparam int BUSW = NP * PW + NP + 1;
    localparam int W    = NR + BUSW;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    pregno_t       req_pr  [NR];
    wen_t          req_we  [NR];
    value_t        req_val [NR];
    flags_t        req_flg [NR];
    logic [NP-1:0] wr;
    wen_t          we [NP];
    pregno_t       wa [NP];
    value_t        wi [NP];
    flags_t        ti [NP];
    logic          starve;

    always #5 clk = ~clk;

    qupls4_regfile_wport_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_pr    (req_pr),
        .i_req_we    (req_we),
        .i_req_val   (req_val),
        .i_req_flg   (req_flg),
        .o_wr        (wr),
        .o_we        (we),
        .o_wa        (wa),
        .o_i         (wi),
        .o_ti        (ti),
        .o_starve    (starve)
    );

    int            m_rr;
    int            m_cnt [NR];
    logic [NR-1:0] m_grant;
    logic [NR-1:0] last_ready;
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  obs_q [$];
    int            n_checks;
    int            n_fail;

    function automatic logic [BUSW-1:0] pack_bus();
        logic [BUSW-1:0] b;
        b = '0;
        for (int k = 0; k < NP; k++) begin
            if (wr[k]) b[k*PW +: PW] = {we[k], wa[k], wi[k], ti[k]};
            else       b[k*PW +: PW] = {we[k], {(PW - $bits(wen_t)){1'b0}}};
        end
        b[NP*PW +: NP] = wr;
        b[NP*PW + NP]  = starve;
        return b;
    endfunction

    // Reference model: explicit scan list (escalated first, then the rest),
    // then take up to NP entries skipping duplicate destinations.
    task automatic drive_cycle();
        int              order [2*NR];
        int              tk [NP];
        int              no;
        int              ntk;
        bit              dup;
        bit              st;
        logic [NR-1:0]   g;
        logic [BUSW-1:0] b;
        no  = 0;
        ntk = 0;
        g   = '0;
        b   = '0;
        st  = 0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < NR; j++) begin
                int n;
                n = (m_rr + j) % NR;
                if (req_valid[n] && ((p == 0) == (m_cnt[n] == STARVE_LIM))) begin
                    order[no] = n;
                    no++;
                end
            end
        end
        for (int t = 0; t < no; t++) begin
            if (ntk < NP) begin
                dup = 0;
                for (int q = 0; q < ntk; q++) if (req_pr[tk[q]] == req_pr[order[t]]) dup = 1;
                if (!dup) begin
                    tk[ntk] = order[t];
                    ntk++;
                end
            end
        end
        if (!rst) begin
            for (int k = 0; k < ntk; k++) begin
                g[tk[k]] = 1'b1;
                b[k*PW +: PW] = {req_we[tk[k]], req_pr[tk[k]], req_val[tk[k]], req_flg[tk[k]]};
                b[NP*PW + k]  = 1'b1;
            end
            for (int n = 0; n < NR; n++) begin
                if (!req_valid[n] || g[n]) m_cnt[n] = 0;
                else if (m_cnt[n] < STARVE_LIM) m_cnt[n] = m_cnt[n] + 1;
                if (m_cnt[n] == STARVE_LIM) st = 1;
            end
            b[NP*PW + NP] = st;
            if (ntk > 0) m_rr = (tk[ntk-1] + 1) % NR;
        end else begin
            m_rr = 0;
            for (int n = 0; n < NR; n++) m_cnt[n] = 0;
        end
        m_grant = g;
        @(negedge clk);
        last_ready = req_ready;
        exp_q.push_back({g, b});
        @(posedge clk);
        #1;
        obs_q.push_back({last_ready, pack_bus()});
    endtask

    task automatic set_req(input int n, input logic v, input pregno_t pr);
        req_valid[n] = v;
        req_pr[n]    = pr;
        req_we[n]    = wen_t'(10'h3FF >> n);
        req_val[n]   = 64'hD00D_0000_0000_0000 + (64'(n) << 16) + 64'(pr);
        req_flg[n]   = flags_t'(8'h10 + n);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        drive_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        logic [W-1:0] o;
        for (int n = 0; n < NR; n++) set_req(n, 1'b1, pregno_t'(20 + n));
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle();
            n_checks++;
            if (last_ready !== 8'h00 || wr !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_hold: ready=%h wr=%h required ready=00 wr=0", last_ready, wr);
            end
        end
        rst = 1'b0;
        drive_cycle();
        n_checks++;
        if (last_ready !== 8'h0F || wr !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_release: ready=%h wr=%h required ready=0f wr=f", last_ready, wr);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_sb: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_four_sparse();
        logic [W-1:0] e;
        logic [W-1:0] o;
        apply_reset();
        req_valid = '0;
        set_req(0, 1'b1, 9'd100);
        set_req(2, 1'b1, 9'd102);
        set_req(5, 1'b1, 9'd105);
        set_req(7, 1'b1, 9'd107);
        drive_cycle();
        n_checks++;
        if (last_ready !== 8'b1010_0101 || wr !== 4'b1111 || wa[0] !== 9'd100 ||
            wa[1] !== 9'd102 || wa[2] !== 9'd105 || wa[3] !== 9'd107) begin
            n_fail++;
            $display("FAIL four_sparse: ready=%h wr=%b wa=%0d,%0d,%0d,%0d required a5 1111 100,102,105,107",
                     last_ready, wr, wa[0], wa[1], wa[2], wa[3]);
        end
        req_valid = '0;
        drive_cycle();
        n_checks++;
        if (wr !== 4'b0000 || we[0] !== '0) begin
            n_fail++;
            $display("FAIL idle_after: wr=%b we0=%h required wr=0000 we0=0", wr, we[0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL four_sparse_sb: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        logic [W-1:0] o;
        apply_reset();
        for (int n = 0; n < NR; n++) set_req(n, 1'b1, pregno_t'(200 + n));
        for (int c = 0; c < 4; c++) begin
            drive_cycle();
            n_checks++;
            if (last_ready !== ((c % 2) ? 8'hF0 : 8'h0F) || wr !== 4'hF) begin
                n_fail++;
                $display("FAIL alternate c%0d: ready=%h wr=%h required %h f", c, last_ready, wr,
                         (c % 2) ? 8'hF0 : 8'h0F);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back_sb: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_dup_preg();
        logic [W-1:0] e;
        logic [W-1:0] o;
        int           hits;
        apply_reset();
        req_valid = '0;
        set_req(1, 1'b1, 9'd42);
        set_req(3, 1'b1, 9'd42);
        for (int c = 0; c < 2; c++) begin
            drive_cycle();
            n_checks++;
            if (last_ready !== ((c == 0) ? 8'b0000_0010 : 8'b0000_1000)) begin
                n_fail++;
                $display("FAIL dup_grant c%0d: ready=%b", c, last_ready);
            end
            hits = 0;
            for (int k = 0; k < NP; k++) if (wr[k] && wa[k] == 9'd42) hits++;
            n_checks++;
            if (hits !== 1) begin
                n_fail++;
                $display("FAIL dup_ports c%0d: ports writing 42=%0d required 1", c, hits);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL dup_preg_sb: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_starvation();
        logic [W-1:0] e;
        logic [W-1:0] o;
        int           cyc;
        bit           found;
        apply_reset();
        req_valid = '0;
        set_req(6, 1'b1, 9'd77);
        drive_cycle();
        for (int n = 0; n < NR; n++) set_req(n, 1'b1, 9'd99);
        found = 0;
        cyc   = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            drive_cycle();
            cyc++;
            if (starve) found = 1;
        end
        n_checks++;
        if (!found || cyc !== 7) begin
            n_fail++;
            $display("FAIL starve_rise: seen=%0d after %0d cycles required seen=1 after 7", found, cyc);
        end
        drive_cycle();
        n_checks++;
        if (last_ready !== 8'h40 || wr !== 4'b0001 || wi[0] !== req_val[6]) begin
            n_fail++;
            $display("FAIL starve_grant: ready=%h wr=%b i0=%h required 40 0001 %h",
                     last_ready, wr, wi[0], req_val[6]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL starvation_sb: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] e;
        logic [W-1:0] o;
        apply_reset();
        req_valid = '0;
        for (int n = 0; n < 3; n++) set_req(n, 1'b1, pregno_t'(300 + n));
        drive_cycle();
        n_checks++;
        if (last_ready !== 8'h07 || wr !== 4'b0111) begin
            n_fail++;
            $display("FAIL pre_reset: ready=%h wr=%b required 07 0111", last_ready, wr);
        end
        rst = 1'b1;
        drive_cycle();
        n_checks++;
        if (wr !== 4'b0000 || last_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: wr=%b ready=%h required 0000 00", wr, last_ready);
        end
        rst = 1'b0;
        for (int n = 0; n < 6; n++) set_req(n, 1'b1, pregno_t'(300 + n));
        drive_cycle();
        n_checks++;
        if (last_ready !== 8'h0F) begin
            n_fail++;
            $display("FAIL ptr_cleared: ready=%h required 0f", last_ready);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mid_reset_sb: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [W-1:0] o;
        apply_reset();
        m_grant = '1;
        for (int c = 0; c < 300; c++) begin
            for (int n = 0; n < NR; n++) begin
                if (!req_valid[n] || m_grant[n]) begin
                    req_valid[n] = ($urandom_range(0, 4) != 0);
                    req_pr[n]    = pregno_t'($urandom_range(0, 2));
                    req_we[n]    = wen_t'($urandom);
                    req_val[n]   = {$urandom, $urandom};
                    req_flg[n]   = flags_t'($urandom);
                end
            end
            drive_cycle();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random_sb: got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_rr      = 0;
        m_grant   = '0;
        for (int n = 0; n < NR; n++) m_cnt[n] = 0;
        rst       = 1'b1;
        req_valid = '0;
        for (int n = 0; n < NR; n++) set_req(n, 1'b0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_four_sparse();
        test_back_to_back();
        test_dup_preg();
        test_starvation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
